// File: rtl/rmii_pkg.sv
// Types and constants shared by the RMII receive deserializer and transmit serializer.
package rmii_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPreamble,
    StData,
    StDrop
  } rmii_state_e;

  localparam logic [1:0]  PREAMBLE_DIBIT   = 2'b01;
  localparam logic [1:0]  SFD_DIBIT        = 2'b11;
  localparam int unsigned RMII_BYTE_DIBITS = 4;

endpackage

// File: rtl/rmii_rxd.sv
// RMII receive deserializer: strips preamble/SFD, rebuilds LSB-first dibits into bytes and
// frames them with start/end/error strobes.
module rmii_rxd
  import rmii_pkg::*;
#(
  parameter int unsigned MIN_PREAMBLE    = 8,
  parameter int unsigned MAX_FRAME_BYTES = 1522
) (
  input  logic        I_clk50m,
  input  logic        I_rst_n,
  input  logic        I_crs_dv,
  input  logic [1:0]  I_rxd,
  output logic [7:0]  O_data,
  output logic        O_valid,
  output logic        O_sof,
  output logic        O_eof,
  output logic        O_err,
  output logic [10:0] O_byte_cnt
);

  localparam logic [1:0]  LastPos  = 2'(RMII_BYTE_DIBITS - 1);
  localparam logic [10:0] MaxBytes = 11'(MAX_FRAME_BYTES);

  rmii_state_e state_q, state_d;
  logic [7:0]  pre_cnt_q, pre_cnt_d;
  logic [1:0]  pos_q, pos_d;
  logic        low_q, low_d;
  // Holds the first three dibits of the byte in flight; the fourth comes straight from I_rxd.
  logic [5:0]  sh_q, sh_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        sof_q, sof_d;
  logic        eof_q, eof_d;
  logic        err_q, err_d;
  logic [10:0] cnt_q, cnt_d;

  logic [7:0]  pre_cur;

  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    pos_d     = pos_q;
    low_d     = low_q;
    sh_d      = sh_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    sof_d     = 1'b0;
    eof_d     = 1'b0;
    err_d     = 1'b0;
    cnt_d     = cnt_q;
    // A carrier rising in IDLE is judged as the first preamble dibit with a cleared count.
    pre_cur   = (state_q == StIdle) ? 8'd0 : pre_cnt_q;

    unique case (state_q)
      StIdle, StPreamble: begin
        if (!I_crs_dv) begin
          state_d = StIdle;
        end else begin
          state_d   = StPreamble;
          pre_cnt_d = pre_cur;
          if (I_rxd == PREAMBLE_DIBIT) begin
            if (pre_cur != 8'hff) pre_cnt_d = pre_cur + 8'd1;
          end else if (I_rxd == SFD_DIBIT) begin
            if (32'(pre_cur) >= MIN_PREAMBLE) begin
              state_d = StData;
              pos_d   = 2'd0;
              low_d   = 1'b0;
              cnt_d   = 11'd0;
            end else begin
              state_d = StDrop;
            end
          end else if (I_rxd != 2'b00) begin
            state_d = StDrop;
          end
        end
      end

      StData: begin
        if (!I_crs_dv && pos_q == 2'd0) begin
          eof_d   = 1'b1;
          state_d = StIdle;
        end else if (!I_crs_dv && low_q) begin
          eof_d   = 1'b1;
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          // A lone crs_dv drop mid-byte is RMII carrier toggling; the dibit is still data.
          low_d = !I_crs_dv;
          sh_d  = {I_rxd, sh_q[5:2]};
          pos_d = pos_q + 2'd1;
          if (pos_q == LastPos) begin
            pos_d = 2'd0;
            if (cnt_q == MaxBytes) begin
              eof_d   = 1'b1;
              err_d   = 1'b1;
              state_d = StDrop;
            end else begin
              valid_d = 1'b1;
              data_d  = {I_rxd, sh_q};
              sof_d   = (cnt_q == 11'd0);
              cnt_d   = cnt_q + 11'd1;
            end
          end
        end
      end

      StDrop: begin
        if (!I_crs_dv) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge I_clk50m or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q   <= StIdle;
      pre_cnt_q <= 8'd0;
      pos_q     <= 2'd0;
      low_q     <= 1'b0;
      sh_q      <= 6'd0;
      data_q    <= 8'd0;
      valid_q   <= 1'b0;
      sof_q     <= 1'b0;
      eof_q     <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= 11'd0;
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      pos_q     <= pos_d;
      low_q     <= low_d;
      sh_q      <= sh_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      sof_q     <= sof_d;
      eof_q     <= eof_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign O_data     = data_q;
  assign O_valid    = valid_q;
  assign O_sof      = sof_q;
  assign O_eof      = eof_q;
  assign O_err      = err_q;
  assign O_byte_cnt = cnt_q;

endmodule

// File: tb/tb_rmii_rxd.sv
// Bench for rmii_rxd: frames are described at byte level and the expected output trace is
// derived from those descriptions, then compared cycle by cycle against the DUT.
module tb_rmii_rxd;

  localparam int MinPre   = 8;
  localparam int MaxBytes = 4;

  logic        clk;
  logic        rst_n;
  logic        crs_dv;
  logic [1:0]  rxd;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        o_sof;
  logic        o_eof;
  logic        o_err;
  logic [10:0] o_byte_cnt;

  rmii_rxd #(
    .MIN_PREAMBLE   (MinPre),
    .MAX_FRAME_BYTES(MaxBytes)
  ) dut (
    .I_clk50m  (clk),
    .I_rst_n   (rst_n),
    .I_crs_dv  (crs_dv),
    .I_rxd     (rxd),
    .O_data    (o_data),
    .O_valid   (o_valid),
    .O_sof     (o_sof),
    .O_eof     (o_eof),
    .O_err     (o_err),
    .O_byte_cnt(o_byte_cnt)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int model_cnt = 0;

  // Per-cycle stimulus and the output expected after the edge that samples it.
  logic       q_crs[$];
  logic [1:0] q_rxd[$];
  logic       q_v[$];
  logic [7:0] q_d[$];
  logic       q_s[$];
  logic       q_e[$];
  logic       q_r[$];
  int         q_c[$];

  logic [7:0] fb[$];
  logic [3:0] ftog[$];
  logic [3:0] tog_tab[5];

  task automatic chk(input string tag, input int c, input logic [15:0] got,
                     input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, c, got, exp);
    end
  endtask

  task automatic push(input logic c, input logic [1:0] d, input logic v, input logic [7:0] dat,
                      input logic s, input logic e, input logic r);
    q_crs.push_back(c);
    q_rxd.push_back(d);
    q_v.push_back(v);
    q_d.push_back(dat);
    q_s.push_back(s);
    q_e.push_back(e);
    q_r.push_back(r);
    q_c.push_back(model_cnt);
  endtask

  task automatic pushd(input logic c, input logic [1:0] d);
    push(c, d, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, cyc, 16'(o_valid), 16'd0);
    chk({tag, "_sof"}, cyc, 16'(o_sof), 16'd0);
    chk({tag, "_eof"}, cyc, 16'(o_eof), 16'd0);
    chk({tag, "_err"}, cyc, 16'(o_err), 16'd0);
    chk({tag, "_data"}, cyc, 16'(o_data), 16'd0);
    chk({tag, "_cnt"}, cyc, 16'(o_byte_cnt), 16'd0);
  endtask

  // Frame = pre_a x 01, n00 x 00, pre_b x 01, SFD, bytes in fb (toggle masks in ftog),
  // then either a clean end or a two-cycle carrier loss after abort_m dibits of byte abort_b,
  // followed by carrier-off cycles (gap counts the terminating cycle of a clean end).
  task automatic add_frame(input int pre_a, input int n00, input int pre_b, input int abort_b,
                           input int abort_m, input int gap);
    bit         acc;
    bit         done;
    bit         ended;
    int         emitted;
    logic [7:0] cur;
    logic [1:0] dib;
    logic       c;
    acc     = (pre_a + pre_b) >= MinPre;
    done    = !acc;
    ended   = 1'b0;
    emitted = 0;
    repeat (pre_a) pushd(1'b1, 2'b01);
    repeat (n00) pushd(1'b1, 2'b00);
    repeat (pre_b) pushd(1'b1, 2'b01);
    if (acc) model_cnt = 0;
    pushd(1'b1, 2'b11);
    for (int b = 0; b < fb.size(); b++) begin
      cur = fb[b];
      if (b == abort_b) begin
        for (int k = 0; k < abort_m; k++) pushd(1'b1, cur[2*k +: 2]);
        pushd(1'b0, cur[2*abort_m +: 2]);
        push(1'b0, 2'b00, 1'b0, 8'h00, 1'b0, !done, !done);
        done  = 1'b1;
        ended = 1'b1;
        break;
      end
      for (int k = 0; k < 4; k++) begin
        dib = cur[2*k +: 2];
        c   = !(!done && k != 0 && ftog[b][k]);
        if (k == 3 && !done) begin
          if (emitted == MaxBytes) begin
            push(c, dib, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
            done = 1'b1;
          end else begin
            emitted++;
            model_cnt++;
            push(c, dib, 1'b1, cur, emitted == 1, 1'b0, 1'b0);
          end
        end else begin
          pushd(c, dib);
        end
      end
    end
    if (!ended) begin
      push(1'b0, 2'($urandom), 1'b0, 8'h00, 1'b0, !done, 1'b0);
      repeat (gap - 1) pushd(1'b0, 2'b00);
    end else begin
      repeat (gap - 1) pushd(1'b0, 2'b00);
    end
  endtask

  task automatic run_stream();
    for (int i = 0; i < q_crs.size(); i++) begin
      crs_dv = q_crs[i];
      rxd    = q_rxd[i];
      @(posedge clk);
      #1;
      chk("valid", cyc, 16'(o_valid), 16'(q_v[i]));
      chk("sof", cyc, 16'(o_sof), 16'(q_s[i]));
      chk("eof", cyc, 16'(o_eof), 16'(q_e[i]));
      chk("err", cyc, 16'(o_err), 16'(q_r[i]));
      chk("byte_cnt", cyc, 16'(o_byte_cnt), 16'(q_c[i]));
      if (q_v[i]) chk("data", cyc, 16'(o_data), 16'(q_d[i]));
      cyc++;
    end
    q_crs.delete(); q_rxd.delete(); q_v.delete(); q_d.delete();
    q_s.delete(); q_e.delete(); q_r.delete(); q_c.delete();
  endtask

  initial begin
    tog_tab = '{4'b0000, 4'b0010, 4'b0100, 4'b1000, 4'b1010};
    rst_n  = 1'b0;
    crs_dv = 1'b0;
    rxd    = 2'b00;
    #5;
    check_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Clean frame, then the same frame with carrier toggles at positions 1 and 3 of 0x5F.
    fb = {8'hA1, 8'h5F}; ftog = {4'b0000, 4'b0000};
    add_frame(15, 0, 0, -1, 1, 2);
    fb = {8'hA1, 8'h5F}; ftog = {4'b0000, 4'b1010};
    add_frame(15, 0, 0, -1, 1, 2);
    run_stream();

    // Short preamble is dropped; the next valid frame follows with no gap beyond one cycle.
    fb = {8'hA1, 8'h5F}; ftog = {4'b0000, 4'b0000};
    add_frame(3, 0, 0, -1, 1, 1);
    fb = {8'h12, 8'h34}; ftog = {4'b0000, 4'b0000};
    add_frame(9, 0, 0, -1, 1, 1);
    run_stream();

    // Mid-byte loss after 2 dibits of byte 3, then oversize (6 bytes against a limit of 4).
    fb = {8'hA1, 8'h5F, 8'hC3}; ftog = {4'b0000, 4'b0000, 4'b0000};
    add_frame(10, 0, 0, 2, 2, 2);
    fb = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    ftog = {4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b1000, 4'b0000};
    add_frame(10, 0, 0, -1, 1, 2);
    run_stream();

    // Preamble boundaries: 7 rejected, 8 accepted, 00 lead-in holds, 260 saturates.
    fb = {8'hE7}; ftog = {4'b0000};
    add_frame(7, 0, 0, -1, 1, 1);
    add_frame(8, 0, 0, -1, 1, 1);
    add_frame(4, 3, 4, -1, 1, 1);
    add_frame(0, 2, 260, -1, 1, 2);
    run_stream();

    // Carrier loss inside preamble, then a 10 dibit, neither of which may frame anything.
    repeat (5) pushd(1'b1, 2'b01);
    pushd(1'b0, 2'b00);
    repeat (10) pushd(1'b1, 2'b01);
    pushd(1'b1, 2'b10);
    pushd(1'b1, 2'b11);
    repeat (4) pushd(1'b1, 2'b11);
    pushd(1'b0, 2'b00);
    fb = {8'h9D}; ftog = {4'b0000};
    add_frame(8, 0, 0, -1, 1, 2);
    run_stream();

    // Reset in the middle of a frame.
    repeat (10) pushd(1'b1, 2'b01);
    model_cnt = 0;
    pushd(1'b1, 2'b11);
    pushd(1'b1, 2'b00);
    pushd(1'b1, 2'b11);
    pushd(1'b1, 2'b11);
    model_cnt++;
    push(1'b1, 2'b00, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
    pushd(1'b1, 2'b10);
    pushd(1'b1, 2'b01);
    run_stream();
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("rst_async");
    model_cnt = 0;
    repeat (3) pushd(1'b1, 2'b11);
    run_stream();
    rst_n = 1'b1;
    repeat (3) pushd(1'b0, 2'b00);
    fb = {8'h5A, 8'hA5}; ftog = {4'b0000, 4'b0000};
    add_frame(12, 0, 0, -1, 1, 2);
    run_stream();

    // Randomised frames.
    for (int f = 0; f < 40; f++) begin
      int na, nz, nb, nbytes, ab, am, gap;
      na     = $urandom_range(3, 12);
      nz     = $urandom_range(0, 2);
      nb     = $urandom_range(0, 4);
      nbytes = $urandom_range(0, 6);
      fb.delete();
      ftog.delete();
      for (int b = 0; b < nbytes; b++) begin
        fb.push_back(8'($urandom));
        ftog.push_back(tog_tab[$urandom_range(0, 4)]);
      end
      ab = -1;
      am = 1;
      if (nbytes > 0 && $urandom_range(0, 3) == 0) begin
        ab = $urandom_range(0, nbytes - 1);
        am = $urandom_range(1, 2);
      end
      gap = $urandom_range(1, 3);
      add_frame(na, nz, nb, ab, am, gap);
      run_stream();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
